spi_master_fifo: RTL and testbench
==================================

# spi_master_fifo

Parametrised SPI master for the Qsys peripheral set, successor to the fixed 8-bit/mode-0 TFT SPI port. It adds runtime-selectable CPOL/CPHA/bit order, a programmable SCLK divider, configurable word width and slave count, and TX/RX FIFOs so the CPU can queue bursts. It sits on the Avalon-MM slave side of the system interconnect and drives the external SPI pins directly.

## Interface
- DATA_W, 8: SPI word width, 4..16.
- NUM_SS, 1: number of slave-select lines, 1..16.
- FIFO_DEPTH, 8: TX and RX FIFO depth each; power of two, ≥2.
- DEFAULT_DIV, 390: reset value of DIVISOR (half-period = DIV+1 clk).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  slave select from interconnect.
- addr  in  3  register address.
- write_n  in  1  active-low write strobe, single-cycle.
- read_n  in  1  active-low read strobe, single-cycle.
- writedata  in  16  write data.
- readdata  out  16  registered read data, valid 1 cycle after read.
- irq  out  1  registered interrupt.
- SCLK  out  1  SPI clock.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- SS_n  out  NUM_SS  active-low slave selects.

## Operation
- Registers: 0 RXDATA (r, pops RX FIFO); 1 TXDATA (w, pushes TX FIFO); 2 STATUS (r; any write clears TOE/ROE); 3 CONTROL (r/w); 4 DIVISOR (r/w, 16 bit); 5 SSEL (r/w, NUM_SS bits, reset 1).
- STATUS: [0] TMT (TX empty and IDLE), [1] TRDY (TX not full), [2] RRDY (RX not empty), [3] TOE, [4] ROE, [5] BUSY, [15:8] RX count.
- CONTROL: [0] CPOL, [1] CPHA, [2] LSBFIRST, [3] SSO (force SS active), [4] IE_TRDY, [5] IE_RRDY, [6] IE_ERR, [7] IE_TMT, [8] LOOPBACK (see Configuration). Reset 0.
- Words are DATA_W LSBs of writedata; RXDATA zero-extended. Unused bits read 0.
- FSM: IDLE → LEAD when TX non-empty (pop word, latch CPOL/CPHA/LSBFIRST/DIVISOR into shadows) → SHIFT (2·DATA_W half-periods) → TRAIL (one half-period) → SHIFT if TX non-empty (pop, SS held, shadows unchanged), else IDLE.
- SS_n[i] = ~SSEL[i] when state ≠ IDLE or SSO; else 1.
- SCLK = CPOL in IDLE/LEAD/TRAIL; toggles each half-period tick in SHIFT.
- CPHA=0: first bit on MOSI on entering SHIFT; sample on leading edge, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- End of SHIFT: received word pushed to RX; if RX full, word dropped, ROE=1.
- TXDATA write with TX full: dropped, TOE=1. RXDATA read when empty: returns 0, no pop.
- irq = (TRDY&IE_TRDY)|(RRDY&IE_RRDY)|((TOE|ROE)&IE_ERR)|(TMT&IE_TMT), registered.

## Timing
- Reset: SCLK=0, MOSI=0, SS_n=all 1, readdata=0, irq=0, FIFOs empty, state IDLE, DIVISOR=DEFAULT_DIV.
- Half-period counter reloads at 0 on every state entry; tick when count==DIV.
- TXDATA write at cycle N (TX empty, IDLE): LEAD entered N+2, SS_n asserted N+2.
- Status reflects a push/pop on the cycle after the access.
- Simultaneous push and pop on one FIFO: both performed; count unchanged; allowed when full (TX) or empty-plus-push (RX pass not allowed: pop sees empty).
- CONTROL/DIVISOR writes mid-transfer take effect at next IDLE→LEAD only; SSEL writes apply immediately.
- STATUS clear and same-cycle new error: error wins (bit stays 1).
- Reset mid-transfer: immediate return to reset values; partial word discarded.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined: CONTROL[8] routes MOSI internally to the sampling input; external MISO ignored, pins still driven.
- Undefined: CONTROL[8] reads 0, writes ignored, MISO always used.

## Test plan
- Mode 0, DIV=1, DATA_W=8: write 0xA5, MISO tied 1 → MOSI 1,0,1,0,0,1,0,1; SCLK period 4 clk; RXDATA=0xFF; TMT=1 after TRAIL.
- Mode 3, LSBFIRST, write 0x01,0x80 back-to-back → SS_n held low across both words, MOSI first bit 1 then 0, two RX entries.
- Fill TX with FIFO_DEPTH+1 words while SCLK slow → TOE=1, exactly FIFO_DEPTH+1? no: FIFO_DEPTH words transmitted plus one in flight, extra dropped; STATUS write clears TOE.
- Send FIFO_DEPTH+1 words without reading → ROE=1, RX count=FIFO_DEPTH, first FIFO_DEPTH words returned in order.
- IE_RRDY=1, one transfer → irq rises 1 cycle after RX push, falls 1 cycle after read empties RX.
- Loopback (macro on, CONTROL[8]=1), write 0x3C, MISO=0 → RXDATA=0x3C; macro off → RXDATA=0x00.

Source files
------------

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, runtime CPOL/CPHA/bit order and SCLK divider.
// Optional internal loopback when SPI_MASTER_LOOPBACK_EN is defined.

module spi_master_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = mem[rp];
endmodule

module spi_master_fifo #(
    parameter int DATA_W      = 8,
    parameter int NUM_SS      = 1,
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 390
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic [2:0]        addr,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_n
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LEAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] TRAIL = 2'd3;

    function automatic logic obit(input logic [DATA_W-1:0] x, input logic lsb);
        return lsb ? x[0] : x[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] sout(input logic [DATA_W-1:0] x,
                                               input logic lsb);
        return lsb ? (x >> 1) : (x << 1);
    endfunction

    function automatic logic [DATA_W-1:0] sinb(input logic [DATA_W-1:0] x,
                                               input logic b, input logic lsb);
        return lsb ? {b, x[DATA_W-1:1]} : {x[DATA_W-2:0], b};
    endfunction

    logic              wr_en;
    logic              rd_en;
    logic              ctrl_cpol, ctrl_cpha, ctrl_lsb, ctrl_sso;
    logic              ie_trdy, ie_rrdy, ie_err, ie_tmt;
    logic              ctrl_lb;
    logic [15:0]       divisor;
    logic [NUM_SS-1:0] ssel;
    logic              toe, roe;

    logic [1:0]        state;
    logic [15:0]       cnt;
    logic [EW-1:0]     edge_cnt;
    logic              sclk_t;
    logic              mosi_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_nx;
    logic              sh_cpol, sh_cpha, sh_lsb;
    logic [15:0]       sh_div;
    logic              miso_in;

    logic [DATA_W-1:0] tx_head, rx_head;
    logic [CW-1:0]     tx_count, rx_count;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              tx_req, tx_push, tx_pop, toe_set;
    logic              rx_push, rx_push_ok, rx_pop, roe_set;
    logic              tick, last, lead, shift_tick, sample;
    logic              tmt, trdy, rrdy, busy;
    logic [15:0]       rd_mux;

    assign wr_en = cs & ~write_n;
    assign rd_en = cs & ~read_n;

`ifdef SPI_MASTER_LOOPBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     ctrl_lb <= 1'b0;
        else if (wr_en && addr == 3'd3)   ctrl_lb <= writedata[8];
    end
    assign miso_in = ctrl_lb ? mosi_q : MISO;
`else
    assign ctrl_lb = 1'b0;
    assign miso_in = MISO;
`endif

    assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_count == '0);

    assign tick       = (cnt == sh_div);
    assign last       = (edge_cnt == LAST_EDGE);
    assign lead       = ~edge_cnt[0];
    assign shift_tick = (state == SHIFT) && tick;
    assign sample     = shift_tick && (lead ^ sh_cpha);
    assign rx_nx      = sample ? sinb(rx_sr, miso_in, sh_lsb) : rx_sr;
    assign rx_push    = shift_tick && last;
    assign tx_pop     = ~tx_empty &&
                        ((state == IDLE) || (state == TRAIL && tick));

    // A push into a full FIFO is still taken when a pop frees a slot.
    assign tx_req     = wr_en && addr == 3'd1;
    assign tx_push    = tx_req && (~tx_full || tx_pop);
    assign toe_set    = tx_req && tx_full && ~tx_pop;
    assign rx_pop     = rd_en && addr == 3'd0 && ~rx_empty;
    assign rx_push_ok = rx_push && (~rx_full || rx_pop);
    assign roe_set    = rx_push && rx_full && ~rx_pop;

    spi_master_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .pop     (tx_pop),
        .wdata   (writedata[DATA_W-1:0]),
        .rdata   (tx_head),
        .count   (tx_count)
    );

    spi_master_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push_ok),
        .pop     (rx_pop),
        .wdata   (rx_nx),
        .rdata   (rx_head),
        .count   (rx_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            sclk_t   <= 1'b0;
            mosi_q   <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sh_cpol  <= 1'b0;
            sh_cpha  <= 1'b0;
            sh_lsb   <= 1'b0;
            sh_div   <= 16'(DEFAULT_DIV);
        end else begin
            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        state   <= LEAD;
                        cnt     <= '0;
                        tx_sr   <= tx_head;
                        sh_cpol <= ctrl_cpol;
                        sh_cpha <= ctrl_cpha;
                        sh_lsb  <= ctrl_lsb;
                        sh_div  <= divisor;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        edge_cnt <= '0;
                        sclk_t   <= sh_cpol;
                        if (!sh_cpha) begin
                            mosi_q <= obit(tx_sr, sh_lsb);
                            tx_sr  <= sout(tx_sr, sh_lsb);
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        cnt      <= '0;
                        edge_cnt <= edge_cnt + 1'b1;
                        sclk_t   <= ~sclk_t;
                        rx_sr    <= rx_nx;
                        // CPHA=1 drives on leading edges, CPHA=0 on trailing.
                        if (sh_cpha ? lead : (!lead && !last)) begin
                            mosi_q <= obit(tx_sr, sh_lsb);
                            tx_sr  <= sout(tx_sr, sh_lsb);
                        end
                        if (last) state <= TRAIL;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        cnt <= '0;
                        if (!tx_empty) begin
                            state    <= SHIFT;
                            edge_cnt <= '0;
                            sclk_t   <= sh_cpol;
                            if (!sh_cpha) begin
                                mosi_q <= obit(tx_head, sh_lsb);
                                tx_sr  <= sout(tx_head, sh_lsb);
                            end else begin
                                tx_sr  <= tx_head;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tmt  = tx_empty && (state == IDLE);
    assign trdy = ~tx_full;
    assign rrdy = ~rx_empty;
    assign busy = (state != IDLE);

    always_comb begin
        rd_mux = '0;
        case (addr)
            3'd0: rd_mux = rx_empty ? 16'd0 : 16'(rx_head);
            3'd2: rd_mux = {8'(rx_count), 2'b00, busy, roe, toe, rrdy, trdy, tmt};
            3'd3: rd_mux = {7'd0, ctrl_lb, ie_tmt, ie_err, ie_rrdy, ie_trdy,
                            ctrl_sso, ctrl_lsb, ctrl_cpha, ctrl_cpol};
            3'd4: rd_mux = divisor;
            3'd5: rd_mux = 16'(ssel);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_cpol <= 1'b0;
            ctrl_cpha <= 1'b0;
            ctrl_lsb  <= 1'b0;
            ctrl_sso  <= 1'b0;
            ie_trdy   <= 1'b0;
            ie_rrdy   <= 1'b0;
            ie_err    <= 1'b0;
            ie_tmt    <= 1'b0;
            divisor   <= 16'(DEFAULT_DIV);
            ssel      <= NUM_SS'(1);
            toe       <= 1'b0;
            roe       <= 1'b0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_en && addr == 3'd3) begin
                ctrl_cpol <= writedata[0];
                ctrl_cpha <= writedata[1];
                ctrl_lsb  <= writedata[2];
                ctrl_sso  <= writedata[3];
                ie_trdy   <= writedata[4];
                ie_rrdy   <= writedata[5];
                ie_err    <= writedata[6];
                ie_tmt    <= writedata[7];
            end
            if (wr_en && addr == 3'd4) divisor <= writedata;
            if (wr_en && addr == 3'd5) ssel    <= writedata[NUM_SS-1:0];
            // A new error in the same cycle as the clear keeps the flag set.
            if (toe_set)                     toe <= 1'b1;
            else if (wr_en && addr == 3'd2)  toe <= 1'b0;
            if (roe_set)                     roe <= 1'b1;
            else if (wr_en && addr == 3'd2)  roe <= 1'b0;
            if (rd_en) readdata <= rd_mux;
            irq <= (trdy & ie_trdy) | (rrdy & ie_rrdy) |
                   ((toe | roe) & ie_err) | (tmt & ie_tmt);
        end
    end

    assign SCLK = (state == SHIFT) ? sclk_t :
                  (state == IDLE)  ? ctrl_cpol : sh_cpol;
    assign MOSI = mosi_q;
    assign SS_n = (busy || ctrl_sso) ? ~ssel : {NUM_SS{1'b1}};
endmodule

// File: tb/tb_spi_master_fifo.sv
// Scoreboard bench for spi_master_fifo: readdata and MOSI bits are checked
// by monitors against expectations queued by the stimulus thread.

module tb_spi_master_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        irq;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [0:0]  SS_n;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } rd_exp_t;

    rd_exp_t    exp_q[$];
    bit         mosi_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         ss_rises = 0;

    logic       miso_c = 1'b1;
    bit         slave_en = 1'b0;
    logic [7:0] sl_sr = 8'h00;
    int         sl_bits = 0;
    logic [7:0] slave_q[$];

    assign MISO = slave_en ? sl_sr[7] : miso_c;

    spi_master_fifo #(
        .DATA_W(8), .NUM_SS(1), .FIFO_DEPTH(8), .DEFAULT_DIV(390)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs        (cs),
        .addr      (addr),
        .write_n   (write_n),
        .read_n    (read_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .SS_n      (SS_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // readdata monitor
    initial forever begin
        @(posedge clk);
        if (cs && !read_n) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                chk(e.name, 32'(readdata), 32'(e.exp));
            end
        end
    end

    // MOSI is stable at SCLK rising in both mode 0 and mode 3
    initial forever begin
        @(posedge SCLK);
        if (mosi_q.size() != 0) begin
            bit b;
            b = mosi_q.pop_front();
            chk("mosi_bit", 32'(MOSI), 32'(b));
        end
    end

    // mode-0 MSB-first slave
    initial forever begin
        @(negedge SCLK);
        if (slave_en) begin
            if (sl_bits == 7) begin
                sl_bits = 0;
                sl_sr = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
            end else begin
                sl_bits = sl_bits + 1;
                sl_sr = {sl_sr[6:0], 1'b0};
            end
        end
    end

    initial forever begin
        @(posedge SS_n[0]);
        ss_rises++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cs = 1'b1; write_n = 1'b0; addr = a; writedata = d;
        @(posedge clk); #1;
        cs = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp,
                      input string name);
        exp_q.push_back('{exp, name});
        cs = 1'b1; read_n = 1'b0; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; read_n = 1'b1;
    endtask

    task automatic push_bits(input logic [7:0] w, input bit lsb);
        for (int i = 0; i < 8; i++)
            mosi_q.push_back(lsb ? w[i] : w[7-i]);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (SS_n[0] && n < bound) begin
            @(posedge clk); #1; n++;
        end
        while (!SS_n[0] && n < bound) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        if (n >= bound) chk("wait_done_timeout", 32'(n), 32'(bound - 1));
    endtask

    logic [7:0] tx_tab [10] = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F,
                               8'hF0, 8'h69, 8'h96, 8'h81, 8'h7E};
    logic [7:0] sl_tab [9]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                               8'h66, 8'h77, 8'h88, 8'h99};

    initial begin
        int t1, t2;
        logic prev;
        logic [15:0] lb_ctrl, lb_rx;

        #12;
        chk("rst_sclk", 32'(SCLK), 0);
        chk("rst_mosi", 32'(MOSI), 0);
        chk("rst_ss_n", 32'(SS_n), 1);
        chk("rst_readdata", 32'(readdata), 0);
        chk("rst_irq", 32'(irq), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd(3'd2, 16'h0003, "rst_status");
        rd(3'd4, 16'd390,  "rst_divisor");
        rd(3'd5, 16'h0001, "rst_ssel");
        rd(3'd3, 16'h0000, "rst_control");

        // mode 0, DIV=1, 0xA5 with MISO high
        wr(3'd4, 16'd1);
        wr(3'd3, 16'h0000);
        miso_c = 1'b1;
        push_bits(8'hA5, 1'b0);
        wr(3'd1, 16'h00A5);
        chk("ss_n_cycle_n1", 32'(SS_n), 1);
        @(posedge clk); #1;
        chk("ss_n_cycle_n2", 32'(SS_n), 0);
        t1 = -1; t2 = -1; prev = SCLK;
        for (int c = 0; c < 60 && t2 < 0; c++) begin
            @(posedge clk); #1;
            if (SCLK && !prev) begin
                if (t1 < 0) t1 = c;
                else        t2 = c;
            end
            prev = SCLK;
        end
        chk("sclk_period", 32'(t2 - t1), 32'd4);
        wait_done(2000);
        rd(3'd2, 16'h0107, "a5_status");
        rd(3'd0, 16'h00FF, "a5_rxdata");
        rd(3'd2, 16'h0003, "a5_status_empty");

        // TX and RX overflow, DIV=3, slave returns distinct words
        wr(3'd4, 16'd3);
        for (int i = 1; i < 9; i++) slave_q.push_back(sl_tab[i]);
        sl_sr = sl_tab[0]; sl_bits = 0; slave_en = 1'b1;
        for (int i = 0; i < 9; i++) push_bits(tx_tab[i], 1'b0);
        for (int i = 0; i < 10; i++) wr(3'd1, 16'(tx_tab[i]));
        wait_done(4000);
        slave_en = 1'b0;
        rd(3'd2, 16'h081F, "ovf_status");
        wr(3'd2, 16'h0000);
        rd(3'd2, 16'h0807, "ovf_status_cleared");
        for (int i = 0; i < 8; i++) rd(3'd0, 16'(sl_tab[i]), "ovf_rxdata");
        rd(3'd0, 16'h0000, "rx_empty_read");
        rd(3'd2, 16'h0003, "ovf_status_end");

        // irq from RRDY
        wr(3'd4, 16'd1);
        wr(3'd3, 16'h0020);
        @(posedge clk); #1;
        chk("irq_idle", 32'(irq), 0);
        miso_c = 1'b1;
        wr(3'd1, 16'h005A);
        repeat (35) begin @(posedge clk); #1; end
        chk("irq_before_push", 32'(irq), 0);
        @(posedge clk); #1;
        chk("irq_after_push", 32'(irq), 1);
        wait_done(2000);
        rd(3'd0, 16'h00FF, "irq_rxdata");
        chk("irq_at_read", 32'(irq), 1);
        @(posedge clk); #1;
        chk("irq_after_read", 32'(irq), 0);

        // mode 3, LSB first, back-to-back words
        wr(3'd3, 16'h0007);
        ss_rises = 0;
        push_bits(8'h01, 1'b1);
        push_bits(8'h80, 1'b1);
        wr(3'd1, 16'h0001);
        wr(3'd1, 16'h0080);
        wait_done(2000);
        chk("mode3_ss_held", 32'(ss_rises), 1);
        rd(3'd2, 16'h0207, "mode3_status");
        rd(3'd0, 16'h00FF, "mode3_rx0");
        rd(3'd0, 16'h00FF, "mode3_rx1");

        // loopback
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_ctrl = 16'h0100; lb_rx = 16'h003C;
`else
        lb_ctrl = 16'h0000; lb_rx = 16'h0000;
`endif
        wr(3'd3, 16'h0100);
        rd(3'd3, lb_ctrl, "lb_control");
        miso_c = 1'b0;
        wr(3'd1, 16'h003C);
        wait_done(2000);
        rd(3'd0, lb_rx, "lb_rxdata");
        rd(3'd2, 16'h0003, "lb_status");

        // reset in the middle of a transfer
        wr(3'd3, 16'h0000);
        wr(3'd1, 16'h00FF);
        repeat (12) begin @(posedge clk); #1; end
        chk("mid_busy_ss", 32'(SS_n), 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", 32'(SS_n), 1);
        chk("mid_rst_sclk", 32'(SCLK), 0);
        chk("mid_rst_mosi", 32'(MOSI), 0);
        chk("mid_rst_readdata", 32'(readdata), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd(3'd2, 16'h0003, "mid_rst_status");
        rd(3'd4, 16'd390,  "mid_rst_divisor");
        rd(3'd3, 16'h0000, "mid_rst_control");
        repeat (3) begin @(posedge clk); #1; end

        chk("rd_queue_drained", 32'(exp_q.size()), 0);
        chk("mosi_queue_drained", 32'(mosi_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
